// File: rtl/seq_subtract_divider.sv
// Iterative restoring divider: one quotient bit per clock through a single N-bit
// subtract/restore step, with signed/unsigned modes and divide-by-zero/overflow flags.
module seq_subtract_divider #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         signed_op,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic [N-1:0] Q,
    output logic [N-1:0] R,
    output logic         busy,
    output logic         done,
    output logic         DZ,
    output logic         OF
);

    localparam int          CW      = $clog2(N + 1);
    localparam logic [N-1:0] MOST_NEG = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t         r_state;
    state_t         w_next;
    logic [CW-1:0]  r_cnt;
    logic [N-1:0]   r_rem;
    logic [N-1:0]   r_dvd;
    logic [N-1:0]   r_div;
    logic [N-1:0]   r_a;
    logic           r_sign_a;
    logic           r_sign_q;
    logic           r_dz;
    logic           r_of;
    logic [N-1:0]   r_q;
    logic [N-1:0]   r_r;
    logic           r_dz_out;
    logic           r_of_out;

    logic [N-1:0]   w_a_mag;
    logic [N-1:0]   w_b_mag;
    logic           w_b_zero;
    logic [N:0]     w_shift;
    logic           w_ge;
    logic [N-1:0]   w_diff;

    assign w_a_mag  = (signed_op && A[N-1]) ? -A : A;
    assign w_b_mag  = (signed_op && B[N-1]) ? -B : B;
    assign w_b_zero = (B == '0);

    // Trial subtraction on the shifted partial remainder; the compare stands in for
    // the sign bit of an (N+1)-bit difference, and the low N bits are exact when it holds.
    assign w_shift  = {r_rem, r_dvd[N-1]};
    assign w_ge     = (w_shift >= {1'b0, r_div});
    assign w_diff   = w_shift[N-1:0] - r_div;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (start) w_next = w_b_zero ? S_FIX : S_CALC;
            S_CALC: if (r_cnt == CW'(1)) w_next = S_FIX;
            S_FIX:  w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == S_CALC) || (r_state == S_FIX);
        done = (r_state == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_rem    <= '0;
            r_dvd    <= '0;
            r_div    <= '0;
            r_a      <= '0;
            r_sign_a <= 1'b0;
            r_sign_q <= 1'b0;
            r_dz     <= 1'b0;
            r_of     <= 1'b0;
            r_q      <= '0;
            r_r      <= '0;
            r_dz_out <= 1'b0;
            r_of_out <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_cnt    <= CW'(N);
                        r_rem    <= '0;
                        r_dvd    <= w_a_mag;
                        r_div    <= w_b_mag;
                        r_a      <= A;
                        r_sign_a <= signed_op & A[N-1];
                        r_sign_q <= signed_op & (A[N-1] ^ B[N-1]);
                        r_dz     <= w_b_zero;
                        r_of     <= signed_op && (A == MOST_NEG) && (B == '1);
                    end
                end
                S_CALC: begin
                    r_rem <= w_ge ? w_diff : w_shift[N-1:0];
                    r_dvd <= {r_dvd[N-2:0], w_ge};
                    r_cnt <= r_cnt - CW'(1);
                end
                // The most-negative / -1 case falls out naturally: magnitude 2^(N-1)
                // negates back onto itself and the remainder is zero.
                S_FIX: begin
                    if (r_dz) begin
                        r_q      <= '1;
                        r_r      <= r_a;
                        r_dz_out <= 1'b1;
                        r_of_out <= 1'b0;
                    end else begin
                        r_q      <= r_sign_q ? -r_dvd : r_dvd;
                        r_r      <= r_sign_a ? -r_rem : r_rem;
                        r_dz_out <= 1'b0;
                        r_of_out <= r_of;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Q  = r_q;
    assign R  = r_r;
    assign DZ = r_dz_out;
    assign OF = r_of_out;

endmodule

// File: tb/tb_seq_subtract_divider.sv
// Directed + small random bench for seq_subtract_divider with a queue scoreboard.
module tb_seq_subtract_divider;

    localparam int N = 32;
    localparam logic [N-1:0] MOST_NEG = {1'b1, {(N-1){1'b0}}};

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         signed_op = 1'b0;
    logic [N-1:0] A = '0;
    logic [N-1:0] B = '0;
    logic [N-1:0] Q;
    logic [N-1:0] R;
    logic         busy;
    logic         done;
    logic         DZ;
    logic         OF;

    typedef struct packed {
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         dz;
        logic         of;
    } exp_t;

    exp_t         exp_q[$];
    int           checks = 0;
    int           errors = 0;
    logic [N-1:0] prev_q = '0;
    logic [N-1:0] prev_r = '0;

    seq_subtract_divider #(.N(N)) dut (
        .clk(clk), .rst(rst), .start(start), .signed_op(signed_op),
        .A(A), .B(B), .Q(Q), .R(R), .busy(busy), .done(done), .DZ(DZ), .OF(OF)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b, input logic s);
        exp_t e;
        e = '0;
        if (b == '0) begin
            e.q = '1; e.r = a; e.dz = 1'b1;
        end else if (s && a == MOST_NEG && b == '1) begin
            e.q = MOST_NEG; e.r = '0; e.of = 1'b1;
        end else if (s) begin
            e.q = $signed(a) / $signed(b);
            e.r = $signed(a) % $signed(b);
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        return e;
    endfunction

    // Called at a negedge while the DUT is idle; returns at the negedge after the start edge.
    task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic s);
        A = a; B = b; signed_op = s; start = 1'b1;
        exp_q.push_back(model(a, b, s));
        @(negedge clk);
        start = 1'b0;
        A = $urandom; B = $urandom; signed_op = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_done(input int lat0, input int exp_lat, output int nbusy);
        int lat;
        lat = lat0;
        nbusy = 0;
        while (!done && lat < 200) begin
            if (busy) nbusy++;
            @(negedge clk);
            lat++;
        end
        check("latency", 64'(lat), 64'(exp_lat));
    endtask

    task automatic check_result();
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++; errors++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
            return;
        end
        e = exp_q.pop_front();
        check("Q", 64'(Q), 64'(e.q));
        check("R", 64'(R), 64'(e.r));
        check("DZ", 64'(DZ), 64'(e.dz));
        check("OF", 64'(OF), 64'(e.of));
        prev_q = e.q;
        prev_r = e.r;
        @(negedge clk);
        check("done_one_cycle", 64'(done), 64'd0);
    endtask

    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic s, output int nbusy);
        start_op(a, b, s);
        wait_done(1, (b == '0) ? 2 : N + 2, nbusy);
        check_result();
    endtask

    initial begin
        int nb;
        int nd;
        exp_t dropped;

        repeat (3) @(negedge clk);
        check("rst_Q", 64'(Q), 64'd0);
        check("rst_R", 64'(R), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_DZ", 64'(DZ), 64'd0);
        check("rst_OF", 64'(OF), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op(32'd100, 32'd7, 1'b0, nb);
        check("busy_cycles", 64'(nb), 64'(N + 1));

        run_op(32'hFFFFFF9C, 32'd7, 1'b1, nb);
        run_op(32'd100, 32'hFFFFFFF9, 1'b1, nb);
        run_op(32'h12345678, 32'd0, 1'b0, nb);
        run_op(32'h80000000, 32'hFFFFFFFF, 1'b1, nb);
        run_op(32'h80000000, 32'hFFFFFFFF, 1'b0, nb);

        // Second start while in CALC must be ignored.
        start_op(32'd1000, 32'd10, 1'b0);
        repeat (4) @(negedge clk);
        A = 32'd5; B = 32'd1; signed_op = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(6, N + 2, nb);
        check_result();

        // Reset at start edge + 10 aborts the operation.
        start_op(32'h0000DEAD, 32'd3, 1'b0);
        repeat (9) @(negedge clk);
        @(posedge clk);
        rst = 1'b1;
        #1;
        check("abort_Q", 64'(Q), 64'd0);
        check("abort_R", 64'(R), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_DZ", 64'(DZ), 64'd0);
        check("abort_OF", 64'(OF), 64'd0);
        dropped = exp_q.pop_front();
        @(negedge clk);
        rst = 1'b0;
        nd = 0;
        repeat (60) begin
            @(negedge clk);
            if (done) nd++;
        end
        check("no_done_after_abort", 64'(nd), 64'd0);

        run_op(32'hFFFFFFFF, 32'd1, 1'b0, nb);

        // Back-to-back: start in the IDLE cycle right after done; old results hold until FIX.
        run_op(32'd1000, 32'd7, 1'b1, nb);
        start_op(32'hFFFFFFB3, 32'd5, 1'b1);
        repeat (N - 1) @(negedge clk);
        check("hold_Q", 64'(Q), 64'(prev_q));
        check("hold_R", 64'(R), 64'(prev_r));
        wait_done(N, N + 2, nb);
        check_result();

        for (int i = 0; i < 8; i++) begin
            logic [N-1:0] ra;
            logic [N-1:0] rb;
            ra = $urandom;
            rb = (i == 3) ? '0 : ((i % 2 == 0) ? N'($urandom_range(1, 5000)) : N'($urandom));
            run_op(ra, rb, 1'(i % 3 != 0), nb);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
